// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and optional operand forwarding.
// Build macro FORWARD_EN: defined -> MEM/WB forwarding muxes; undefined -> wider hazard stall.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [3:0]  id_aluctrl,
    input  logic        id_alusrc,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        id_memwrite,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [31:0] mem_result,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    input  logic [31:0] wb_result,
    output logic [31:0] ex_src1,
    output logic [31:0] ex_src2,
    output logic [3:0]  ex_aluctrl,
    output logic [31:0] ex_store_data,
    output logic [31:0] ex_pc,
    output logic [4:0]  ex_rd,
    output logic        ex_valid,
    output logic        ex_regwrite,
    output logic        ex_memread,
    output logic        ex_memwrite,
    output logic        load_use_hazard
);

    logic        r_valid;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [31:0] r_pc;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [3:0]  r_aluctrl;
    logic        r_alusrc;
    logic        r_regwrite;
    logic        r_memread;
    logic        r_memwrite;

    logic        w_ex_match;
    logic        w_load_use;
    logic [31:0] w_fwd1;
    logic [31:0] w_fwd2;

    assign w_ex_match = (r_rd == id_rs1) || (r_rd == id_rs2);

`ifdef FORWARD_EN
    // Newest producer wins: MEM stage result beats WB; x0 is never a forwarding target.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  rs,
        input logic [31:0] reg_data,
        input logic        m_we,
        input logic [4:0]  m_rd,
        input logic [31:0] m_val,
        input logic        w_we,
        input logic [4:0]  w_rd,
        input logic [31:0] w_val
    );
        logic [31:0] v;
        if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
            v = m_val;
        end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
            v = w_val;
        end else begin
            v = reg_data;
        end
        return v;
    endfunction

    assign w_fwd1 = fwd_sel(r_rs1, r_rs1_data, mem_regwrite, mem_rd, mem_result,
                            wb_regwrite, wb_rd, wb_result);
    assign w_fwd2 = fwd_sel(r_rs2, r_rs2_data, mem_regwrite, mem_rd, mem_result,
                            wb_regwrite, wb_rd, wb_result);

    assign w_load_use = id_valid && r_valid && r_memread && (r_rd != 5'd0) && w_ex_match;
`else
    logic w_unused;

    assign w_fwd1 = r_rs1_data;
    assign w_fwd2 = r_rs2_data;

    // Without forwarding, any pending write in EX or MEM to a source register must stall ID.
    assign w_load_use = id_valid &&
        ((r_valid && (r_regwrite || r_memread) && (r_rd != 5'd0) && w_ex_match) ||
         (mem_regwrite && (mem_rd != 5'd0) && ((mem_rd == id_rs1) || (mem_rd == id_rs2))));

    assign w_unused = ^{r_rs1, r_rs2, mem_result, wb_rd, wb_regwrite, wb_result};
`endif

    // Stage register update: flush > stall > load-use bubble > normal load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_rs1_data <= 32'd0;
            r_rs2_data <= 32'd0;
            r_imm      <= 32'd0;
            r_pc       <= 32'd0;
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_aluctrl  <= 4'd0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
        end else if (stall) begin
            r_valid    <= r_valid;
            r_regwrite <= r_regwrite;
            r_memread  <= r_memread;
            r_memwrite <= r_memwrite;
        end else begin
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_pc       <= id_pc;
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_aluctrl  <= id_aluctrl;
            r_alusrc   <= id_alusrc;
            if (w_load_use) begin
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
            end else begin
                r_valid    <= id_valid;
                r_regwrite <= id_valid & id_regwrite;
                r_memread  <= id_valid & id_memread;
                r_memwrite <= id_valid & id_memwrite;
            end
        end
    end

    assign ex_src1         = w_fwd1;
    assign ex_src2         = r_alusrc ? r_imm : w_fwd2;
    assign ex_store_data   = w_fwd2;
    assign ex_aluctrl      = r_aluctrl;
    assign ex_pc           = r_pc;
    assign ex_rd           = r_rd;
    assign ex_valid        = r_valid;
    assign ex_regwrite     = r_regwrite;
    assign ex_memread      = r_memread;
    assign ex_memwrite     = r_memwrite;
    assign load_use_hazard = w_load_use;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized run against a
// transaction-level model of the instruction sitting in EX.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_aluctrl;
    logic        id_alusrc, id_regwrite, id_memread, id_memwrite;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_regwrite, wb_regwrite;
    logic [31:0] mem_result, wb_result;
    logic [31:0] ex_src1, ex_src2, ex_store_data, ex_pc;
    logic [3:0]  ex_aluctrl;
    logic [4:0]  ex_rd;
    logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_hazard;

    int checks = 0;
    int errors = 0;

`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_aluctrl(id_aluctrl),
        .id_alusrc(id_alusrc), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_memwrite(id_memwrite), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .mem_result(mem_result), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .wb_result(wb_result), .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_aluctrl(ex_aluctrl),
        .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_rd(ex_rd), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .load_use_hazard(load_use_hazard)
    );

    always #5 clk = ~clk;

    // The instruction currently occupying EX, as the model sees it.
    typedef struct packed {
        logic        valid;
        logic [31:0] a, b, imm, pc;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  op;
        logic        alusrc, rw, mr, mw;
    } ex_t;

    ex_t m;

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] regval);
        if (FWD && mem_regwrite && mem_rd != 5'd0 && mem_rd == rs) return mem_result;
        if (FWD && wb_regwrite && wb_rd != 5'd0 && wb_rd == rs) return wb_result;
        return regval;
    endfunction

    function automatic logic ref_hazard(input ex_t e);
        logic ex_hit, mem_hit;
        ex_hit  = e.valid && e.rd != 5'd0 && (e.rd == id_rs1 || e.rd == id_rs2) &&
                  (FWD ? e.mr : (e.mr || e.rw));
        mem_hit = !FWD && mem_regwrite && mem_rd != 5'd0 && (mem_rd == id_rs1 || mem_rd == id_rs2);
        return id_valid && (ex_hit || mem_hit);
    endfunction

    task automatic clear_inputs();
        stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0; id_pc = 32'd0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0; id_aluctrl = 4'd0;
        id_alusrc = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; mem_result = 32'd0;
        wb_rd = 5'd0; wb_regwrite = 1'b0; wb_result = 32'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        id_valid = 1'b1; id_regwrite = 1'b1; id_rs1_data = 32'h1234;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_hazard} !== 5'b0)
            begin errors++; $display("FAIL reset_ctrl got=%b want=00000",
                {ex_valid, ex_regwrite, ex_memread, ex_memwrite, load_use_hazard}); end
        checks++;
        if ({ex_src1, ex_src2, ex_store_data, ex_pc, ex_aluctrl, ex_rd} !== 137'd0)
            begin errors++; $display("FAIL reset_data src1=%h src2=%h st=%h pc=%h op=%h rd=%h want=0",
                ex_src1, ex_src2, ex_store_data, ex_pc, ex_aluctrl, ex_rd); end
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        clear_inputs();
        id_valid = 1'b1; id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_aluctrl = 4'b0010;
        id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd4; id_regwrite = 1'b1; id_pc = 32'h40;
        step();
        clear_inputs();
        #1;
        checks++;
        if (ex_src1 !== 32'd5 || ex_src2 !== 32'd7)
            begin errors++; $display("FAIL basic_src got=%h/%h want=5/7", ex_src1, ex_src2); end
        checks++;
        if (ex_aluctrl !== 4'b0010 || ex_valid !== 1'b1 || ex_regwrite !== 1'b1 || ex_pc !== 32'h40)
            begin errors++; $display("FAIL basic_ctrl op=%b v=%b rw=%b pc=%h want=0010/1/1/40",
                ex_aluctrl, ex_valid, ex_regwrite, ex_pc); end
    endtask

    task automatic test_forwarding();
        clear_inputs();
        id_valid = 1'b1; id_rs1 = 5'd3; id_rs1_data = 32'h99; id_rd = 5'd6;
        step();
        clear_inputs();
        mem_rd = 5'd3; mem_result = 32'h11; mem_regwrite = 1'b1;
        wb_rd = 5'd3; wb_result = 32'h22; wb_regwrite = 1'b1;
        #1;
        checks++;
        if (ex_src1 !== (FWD ? 32'h11 : 32'h99))
            begin errors++; $display("FAIL fwd_mem_prio got=%h want=%h", ex_src1, FWD ? 32'h11 : 32'h99); end
        mem_regwrite = 1'b0;
        #1;
        checks++;
        if (ex_src1 !== (FWD ? 32'h22 : 32'h99))
            begin errors++; $display("FAIL fwd_wb got=%h want=%h", ex_src1, FWD ? 32'h22 : 32'h99); end
        mem_regwrite = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        #1;
        checks++;
        if (ex_src1 !== 32'h99)
            begin errors++; $display("FAIL fwd_x0 got=%h want=00000099", ex_src1); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        id_valid = 1'b1; id_memread = 1'b1; id_regwrite = 1'b1; id_rd = 5'd5;
        id_rs1 = 5'd1; id_rs2 = 5'd2;
        step();
        clear_inputs();
        id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd5; id_regwrite = 1'b1; id_rd = 5'd7;
        #1;
        checks++;
        if (load_use_hazard !== 1'b1)
            begin errors++; $display("FAIL load_use_raise got=%b want=1", load_use_hazard); end
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_memread !== 1'b0 || ex_regwrite !== 1'b0)
            begin errors++; $display("FAIL load_use_bubble v=%b mr=%b rw=%b want=0/0/0",
                ex_valid, ex_memread, ex_regwrite); end
        checks++;
        if (load_use_hazard !== 1'b0)
            begin errors++; $display("FAIL load_use_clear got=%b want=0", load_use_hazard); end
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        id_valid = 1'b1; id_rs1 = 5'd1; id_rs1_data = 32'hA1; id_rs2 = 5'd2; id_rs2_data = 32'hB2;
        id_rd = 5'd7; id_aluctrl = 4'd3; id_pc = 32'h100; id_regwrite = 1'b1;
        step();
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            id_valid = 1'b1; id_rs1_data = $urandom; id_rs2_data = $urandom; id_pc = $urandom;
            id_rd = 5'($urandom_range(1, 31)); id_aluctrl = 4'($urandom_range(0, 8));
            mem_rd = 5'd1; mem_result = 32'h55; mem_regwrite = (c == 1);
            #1;
            checks++;
            if (ex_src1 !== ((c == 1 && FWD) ? 32'h55 : 32'hA1))
                begin errors++; $display("FAIL stall_src1 cyc=%0d got=%h want=%h", c, ex_src1,
                    (c == 1 && FWD) ? 32'h55 : 32'hA1); end
            checks++;
            if (ex_pc !== 32'h100 || ex_rd !== 5'd7 || ex_aluctrl !== 4'd3 || ex_valid !== 1'b1)
                begin errors++; $display("FAIL stall_hold cyc=%0d pc=%h rd=%0d op=%0d v=%b want=100/7/3/1",
                    c, ex_pc, ex_rd, ex_aluctrl, ex_valid); end
            step();
        end
        flush = 1'b1;
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_regwrite !== 1'b0)
            begin errors++; $display("FAIL flush_over_stall v=%b rw=%b want=0/0", ex_valid, ex_regwrite); end
        clear_inputs();
    endtask

    task automatic test_imm();
        clear_inputs();
        id_valid = 1'b1; id_alusrc = 1'b1; id_imm = 32'hFFFFFFF0; id_rs2 = 5'd2;
        id_rs2_data = 32'h9; id_rs1 = 5'd1; id_rs1_data = 32'h4; id_memwrite = 1'b1;
        step();
        clear_inputs();
        #1;
        checks++;
        if (ex_src2 !== 32'hFFFFFFF0 || ex_store_data !== 32'h9)
            begin errors++; $display("FAIL imm_src2 src2=%h st=%h want=fffffff0/00000009",
                ex_src2, ex_store_data); end
        checks++;
        if (ex_memwrite !== 1'b1 || ex_src1 !== 32'h4)
            begin errors++; $display("FAIL imm_store mw=%b src1=%h want=1/4", ex_memwrite, ex_src1); end
    endtask

    task automatic test_async_reset();
        clear_inputs();
        id_valid = 1'b1; id_rs1_data = 32'hDEAD; id_pc = 32'h200; id_aluctrl = 4'd8;
        id_regwrite = 1'b1; id_rd = 5'd9;
        step();
        stall = 1'b1; flush = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_regwrite, ex_src1, ex_pc, ex_aluctrl} !== 70'd0)
            begin errors++; $display("FAIL async_reset v=%b rw=%b src1=%h pc=%h op=%h want=0",
                ex_valid, ex_regwrite, ex_src1, ex_pc, ex_aluctrl); end
        #1;
        rst_n = 1'b1;
        stall = 1'b0; flush = 1'b0;
        id_rs1_data = 32'hBEEF;
        step();
        checks++;
        if (ex_valid !== 1'b1 || ex_src1 !== 32'hBEEF)
            begin errors++; $display("FAIL post_reset_load v=%b src1=%h want=1/beef", ex_valid, ex_src1); end
    endtask

    task automatic test_random();
        ex_t nxt;
        logic exp_hz;
        logic [31:0] exp_s2;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m = '0;
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 99) < 20);
            flush = ($urandom_range(0, 99) < 8);
            id_valid = ($urandom_range(0, 99) < 75);
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom; id_pc = $urandom;
            id_rs1 = 5'($urandom_range(0, 7)); id_rs2 = 5'($urandom_range(0, 7));
            id_rd = 5'($urandom_range(0, 7)); id_aluctrl = 4'($urandom_range(0, 8));
            id_alusrc = 1'($urandom_range(0, 1)); id_regwrite = 1'($urandom_range(0, 1));
            id_memread = ($urandom_range(0, 99) < 30); id_memwrite = 1'($urandom_range(0, 1));
            mem_rd = 5'($urandom_range(0, 7)); mem_regwrite = 1'($urandom_range(0, 1));
            mem_result = $urandom;
            wb_rd = 5'($urandom_range(0, 7)); wb_regwrite = 1'($urandom_range(0, 1));
            wb_result = $urandom;
            #1;
            exp_hz = ref_hazard(m);
            checks++;
            if (load_use_hazard !== exp_hz)
                begin errors++; $display("FAIL rnd_hazard i=%0d got=%b want=%b", i, load_use_hazard, exp_hz); end
            checks++;
            if ({ex_valid, ex_regwrite, ex_memread, ex_memwrite} !== {m.valid, m.rw, m.mr, m.mw})
                begin errors++; $display("FAIL rnd_ctrl i=%0d got=%b want=%b", i,
                    {ex_valid, ex_regwrite, ex_memread, ex_memwrite}, {m.valid, m.rw, m.mr, m.mw}); end
            if (m.valid) begin
                exp_s2 = m.alusrc ? m.imm : ref_fwd(m.rs2, m.b);
                checks++;
                if (ex_src1 !== ref_fwd(m.rs1, m.a) || ex_src2 !== exp_s2 ||
                    ex_store_data !== ref_fwd(m.rs2, m.b))
                    begin errors++; $display("FAIL rnd_operands i=%0d got=%h/%h/%h want=%h/%h/%h", i,
                        ex_src1, ex_src2, ex_store_data, ref_fwd(m.rs1, m.a), exp_s2, ref_fwd(m.rs2, m.b)); end
                checks++;
                if (ex_pc !== m.pc || ex_rd !== m.rd || ex_aluctrl !== m.op)
                    begin errors++; $display("FAIL rnd_fields i=%0d got=%h/%0d/%0d want=%h/%0d/%0d", i,
                        ex_pc, ex_rd, ex_aluctrl, m.pc, m.rd, m.op); end
            end
            nxt = m;
            if (flush) begin
                nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0;
            end else if (!stall) begin
                nxt = '{valid: id_valid, a: id_rs1_data, b: id_rs2_data, imm: id_imm, pc: id_pc,
                        rs1: id_rs1, rs2: id_rs2, rd: id_rd, op: id_aluctrl, alusrc: id_alusrc,
                        rw: id_valid & id_regwrite, mr: id_valid & id_memread,
                        mw: id_valid & id_memwrite};
                if (exp_hz) begin
                    nxt.valid = 1'b0; nxt.rw = 1'b0; nxt.mr = 1'b0; nxt.mw = 1'b0;
                end
            end
            step();
            m = nxt;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_forwarding();
        test_load_use();
        test_stall_flush();
        test_imm();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
